// File: rtl/rggen_bus_arbiter_pkg.sv
// Shared rggen bus codes and arbiter types, imported by the arbiter and its picker.
package rggen_bus_arbiter_pkg;

  localparam logic [1:0] RGGEN_READ   = 2'b10;
  localparam logic [1:0] RGGEN_WRITE  = 2'b11;
  localparam logic [1:0] RGGEN_OKAY   = 2'b00;
  localparam logic [1:0] RGGEN_SLVERR = 2'b10;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // A single requester still needs a one-bit index/pointer register.
  function automatic int index_width(input int requesters);
    return (requesters > 1) ? $clog2(requesters) : 1;
  endfunction

endpackage

// File: rtl/rggen_rr_picker.sv
// Combinational round-robin pick: first valid requester at or after the pointer, wrapping.
module rggen_rr_picker
  import rggen_bus_arbiter_pkg::*;
#(
  parameter int REQUESTERS  = 2,
  parameter int INDEX_WIDTH = index_width(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0]  i_valid,
  input  logic [INDEX_WIDTH-1:0] i_pointer,
  output logic [REQUESTERS-1:0]  o_winner,
  output logic [INDEX_WIDTH-1:0] o_index,
  output logic                   o_found
);

  logic [INDEX_WIDTH:0]   w_sum;
  logic [INDEX_WIDTH-1:0] w_slot;
  logic [REQUESTERS-1:0]  w_shifted;

  // Walk offsets from farthest to nearest so the nearest valid slot is written last and wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    o_winner  = '0;
    o_index   = '0;
    o_found   = 1'b0;
    w_sum     = '0;
    w_slot    = '0;
    w_shifted = '0;
    for (int offset = REQUESTERS - 1; offset >= 0; offset--) begin
      w_sum = {1'b0, i_pointer} + (INDEX_WIDTH + 1)'(offset);
      if (w_sum >= (INDEX_WIDTH + 1)'(REQUESTERS)) begin
        w_sum = w_sum - (INDEX_WIDTH + 1)'(REQUESTERS);
      end
      w_slot    = w_sum[INDEX_WIDTH-1:0];
      w_shifted = i_valid >> w_slot;
      if (w_shifted[0]) begin
        o_winner = REQUESTERS'(1) << w_slot;
        o_index  = w_slot;
        o_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one rggen bus-side register port among several host adapters.
module rggen_bus_arbiter
  import rggen_bus_arbiter_pkg::*;
#(
  parameter int REQUESTERS    = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [REQUESTERS-1:0]                i_req_valid,
  input  logic [2*REQUESTERS-1:0]              i_req_access,
  input  logic [ADDRESS_WIDTH*REQUESTERS-1:0]  i_req_address,
  input  logic [BUS_WIDTH*REQUESTERS-1:0]      i_req_write_data,
  input  logic [BUS_WIDTH/8*REQUESTERS-1:0]    i_req_strobe,
  output logic [REQUESTERS-1:0]                o_req_ready,
  output logic [1:0]                           o_req_status,
  output logic [BUS_WIDTH-1:0]                 o_req_read_data,
  output logic [REQUESTERS-1:0]                o_grant,
  output logic                                 o_bus_valid,
  output logic [1:0]                           o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]             o_bus_address,
  output logic [BUS_WIDTH-1:0]                 o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]               o_bus_strobe,
  input  logic                                 i_bus_ready,
  input  logic [1:0]                           i_bus_status,
  input  logic [BUS_WIDTH-1:0]                 i_bus_read_data
);

  localparam int                     STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int                     INDEX_WIDTH  = index_width(REQUESTERS);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX   = INDEX_WIDTH'(REQUESTERS - 1);

  arb_state_e             r_state;
  arb_state_e             w_state_next;
  logic [REQUESTERS-1:0]  r_grant;
  logic [REQUESTERS-1:0]  w_grant_next;
  logic [INDEX_WIDTH-1:0] r_grant_index;
  logic [INDEX_WIDTH-1:0] w_grant_index_next;
  logic [INDEX_WIDTH-1:0] r_pointer;
  logic [INDEX_WIDTH-1:0] w_pointer_next;

  logic [REQUESTERS-1:0]  w_winner;
  logic [INDEX_WIDTH-1:0] w_winner_index;
  logic                   w_found;
  logic                   w_complete;

  rggen_rr_picker #(
    .REQUESTERS  (REQUESTERS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_picker (
    .i_valid   (i_req_valid),
    .i_pointer (r_pointer),
    .o_winner  (w_winner),
    .o_index   (w_winner_index),
    .o_found   (w_found)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ARB_IDLE;
      r_grant       <= '0;
      r_grant_index <= '0;
      r_pointer     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_grant_index <= w_grant_index_next;
      r_pointer     <= w_pointer_next;
    end
  end

  // The grant is zero outside BUSY, so the AND-OR mux drives zeros downstream while idle.
  always_comb begin
    o_bus_valid      = 1'b0;
    o_bus_access     = '0;
    o_bus_address    = '0;
    o_bus_write_data = '0;
    o_bus_strobe     = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (r_grant[i]) begin
        o_bus_valid      = o_bus_valid      | i_req_valid[i];
        o_bus_access     = o_bus_access     | i_req_access[2*i +: 2];
        o_bus_address    = o_bus_address    | i_req_address[ADDRESS_WIDTH*i +: ADDRESS_WIDTH];
        o_bus_write_data = o_bus_write_data | i_req_write_data[BUS_WIDTH*i +: BUS_WIDTH];
        o_bus_strobe     = o_bus_strobe     | i_req_strobe[STROBE_WIDTH*i +: STROBE_WIDTH];
      end
    end
  end

  assign w_complete      = o_bus_valid & i_bus_ready;
  assign o_req_ready     = w_complete ? r_grant : '0;
  assign o_req_status    = i_bus_status;
  assign o_req_read_data = i_bus_read_data;
  assign o_grant         = r_grant;

  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_grant_index_next = r_grant_index;
    w_pointer_next     = r_pointer;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_state_next       = ARB_BUSY;
          w_grant_next       = w_winner;
          w_grant_index_next = w_winner_index;
        end
      end
      ARB_BUSY: begin
        // Completion advances the pointer past the winner; an abort leaves it alone.
        if (w_complete) begin
          w_state_next       = ARB_IDLE;
          w_grant_next       = '0;
          w_grant_index_next = '0;
          w_pointer_next     = (r_grant_index == LAST_INDEX) ? '0
                                                             : r_grant_index + INDEX_WIDTH'(1);
        end else if (!o_bus_valid) begin
          w_state_next       = ARB_IDLE;
          w_grant_next       = '0;
          w_grant_index_next = '0;
        end
      end
      default: begin
        w_state_next       = ARB_IDLE;
        w_grant_next       = '0;
        w_grant_index_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed bench for rggen_bus_arbiter: a 2-requester and a 3-requester instance.
module tb_rggen_bus_arbiter;
  import rggen_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 2-requester instance
  logic [1:0]  v2 = '0;
  logic [3:0]  acc2 = '0;
  logic [15:0] addr2 = '0;
  logic [63:0] wd2 = '0;
  logic [7:0]  strb2 = '0;
  logic [1:0]  rdy2, st2, gnt2, ba2;
  logic [31:0] rd2, bwd2;
  logic        bv2;
  logic [7:0]  baddr2;
  logic [3:0]  bs2;
  logic        brdy2 = 1'b0;
  logic [1:0]  bst2 = '0;
  logic [31:0] brd2 = '0;

  // 3-requester instance
  logic [2:0]  v3 = '0;
  logic [5:0]  acc3 = '0;
  logic [23:0] addr3 = '0;
  logic [95:0] wd3 = '0;
  logic [11:0] strb3 = '0;
  logic [2:0]  rdy3, gnt3;
  logic [1:0]  st3, ba3;
  logic [31:0] rd3, bwd3;
  logic        bv3;
  logic [7:0]  baddr3;
  logic [3:0]  bs3;
  logic        brdy3 = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  rggen_bus_arbiter #(.REQUESTERS(2), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(v2), .i_req_access(acc2), .i_req_address(addr2),
    .i_req_write_data(wd2), .i_req_strobe(strb2),
    .o_req_ready(rdy2), .o_req_status(st2), .o_req_read_data(rd2), .o_grant(gnt2),
    .o_bus_valid(bv2), .o_bus_access(ba2), .o_bus_address(baddr2),
    .o_bus_write_data(bwd2), .o_bus_strobe(bs2),
    .i_bus_ready(brdy2), .i_bus_status(bst2), .i_bus_read_data(brd2)
  );

  rggen_bus_arbiter #(.REQUESTERS(3), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(v3), .i_req_access(acc3), .i_req_address(addr3),
    .i_req_write_data(wd3), .i_req_strobe(strb3),
    .o_req_ready(rdy3), .o_req_status(st3), .o_req_read_data(rd3), .o_grant(gnt3),
    .o_bus_valid(bv3), .o_bus_access(ba3), .o_bus_address(baddr3),
    .o_bus_write_data(bwd3), .o_bus_strobe(bs3),
    .i_bus_ready(brdy3), .i_bus_status(2'b00), .i_bus_read_data(32'h0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req2(input int i, input logic v, input logic [1:0] acc,
                          input logic [7:0] addr, input logic [31:0] data);
    v2[i]           = v;
    acc2[2*i +: 2]  = acc;
    addr2[8*i +: 8] = addr;
    wd2[32*i +: 32] = data;
    strb2[4*i +: 4] = 4'hF;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v2 = '0; v3 = '0; brdy2 = 1'b0; brdy3 = 1'b0;
    bst2 = RGGEN_OKAY; brd2 = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if ({bv2, gnt2, rdy2, baddr2, bv3, gnt3, rdy3} !== 18'h0) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: bv=%b gnt=%b rdy=%b addr=%h bv3=%b gnt3=%b rdy3=%b want all 0",
                 c, bv2, gnt2, rdy2, baddr2, bv3, gnt3, rdy3);
      end
    end
  endtask

  task automatic test_single_write();
    set_req2(0, 1'b1, RGGEN_WRITE, 8'h10, 32'hA5A5A5A5);
    #1;
    vectors++;
    if ({bv2, gnt2} !== 3'b000) begin
      miscompares++;
      $display("FAIL single_arb_latency: bv=%b gnt=%b want 0 00", bv2, gnt2);
    end
    tick();
    vectors++;
    if ({bv2, gnt2, ba2, baddr2, bwd2, bs2, rdy2} !== {1'b1, 2'b01, 2'b11, 8'h10, 32'hA5A5A5A5, 4'hF, 2'b00}) begin
      miscompares++;
      $display("FAIL single_bus: bv=%b gnt=%b acc=%b addr=%h data=%h strb=%h rdy=%b want 1 01 11 10 a5a5a5a5 f 00",
               bv2, gnt2, ba2, baddr2, bwd2, bs2, rdy2);
    end
    tick();
    vectors++;
    if ({bv2, gnt2, rdy2} !== 5'b1_01_00) begin
      miscompares++;
      $display("FAIL single_wait: bv=%b gnt=%b rdy=%b want 1 01 00", bv2, gnt2, rdy2);
    end
    brdy2 = 1'b1;
    #1;
    vectors++;
    if (rdy2 !== 2'b01) begin
      miscompares++;
      $display("FAIL single_ready: rdy=%b want 01", rdy2);
    end
    tick();
    set_req2(0, 1'b0, RGGEN_WRITE, 8'h10, 32'hA5A5A5A5);
    brdy2 = 1'b0;
    #1;
    vectors++;
    if ({bv2, gnt2, rdy2} !== 5'b0) begin
      miscompares++;
      $display("FAIL single_release: bv=%b gnt=%b rdy=%b want 0 00 00", bv2, gnt2, rdy2);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_gnt;
    logic [7:0] exp_addr;
    do_reset();
    set_req2(0, 1'b1, RGGEN_READ, 8'h20, 32'h0);
    set_req2(1, 1'b1, RGGEN_READ, 8'h24, 32'h0);
    brdy2 = 1'b1;
    #1;
    vectors++;
    if (gnt2 !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_start: gnt=%b want 00", gnt2);
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_gnt  = (c % 2 == 0) ? 2'b00 : ((c % 4 == 1) ? 2'b01 : 2'b10);
      exp_addr = (exp_gnt == 2'b01) ? 8'h20 : ((exp_gnt == 2'b10) ? 8'h24 : 8'h00);
      vectors++;
      if ({gnt2, rdy2, baddr2} !== {exp_gnt, exp_gnt, exp_addr}) begin
        miscompares++;
        $display("FAIL b2b cycle %0d: gnt=%b rdy=%b addr=%h want %b %b %h",
                 c, gnt2, rdy2, baddr2, exp_gnt, exp_gnt, exp_addr);
      end
    end
    v2 = '0;
    brdy2 = 1'b0;
    tick();
  endtask

  task automatic test_wrap3();
    do_reset();
    v3 = 3'b010;
    addr3 = {8'h32, 8'h31, 8'h30};
    brdy3 = 1'b1;
    tick();
    vectors++;
    if ({gnt3, rdy3, baddr3} !== {3'b010, 3'b010, 8'h31}) begin
      miscompares++;
      $display("FAIL wrap_setup: gnt=%b rdy=%b addr=%h want 010 010 31", gnt3, rdy3, baddr3);
    end
    tick();
    v3 = 3'b011;
    tick();
    vectors++;
    if ({gnt3, rdy3, baddr3} !== {3'b001, 3'b001, 8'h30}) begin
      miscompares++;
      $display("FAIL wrap_grant: gnt=%b rdy=%b addr=%h want 001 001 30", gnt3, rdy3, baddr3);
    end
    tick();
    vectors++;
    if (gnt3 !== 3'b000) begin
      miscompares++;
      $display("FAIL wrap_idle: gnt=%b want 000", gnt3);
    end
    tick();
    vectors++;
    if (gnt3 !== 3'b010) begin
      miscompares++;
      $display("FAIL wrap_pointer: gnt=%b want 010", gnt3);
    end
    v3 = '0;
    brdy3 = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    set_req2(0, 1'b1, RGGEN_WRITE, 8'h40, 32'h1111_0000);
    brdy2 = 1'b1;
    tick();
    tick();
    v2 = '0;
    brdy2 = 1'b0;
    set_req2(1, 1'b1, RGGEN_WRITE, 8'h44, 32'h2222_0000);
    tick();
    vectors++;
    if ({gnt2, bv2, baddr2} !== {2'b10, 1'b1, 8'h44}) begin
      miscompares++;
      $display("FAIL abort_grant: gnt=%b bv=%b addr=%h want 10 1 44", gnt2, bv2, baddr2);
    end
    v2[1] = 1'b0;
    brdy2 = 1'b1;
    #1;
    vectors++;
    if ({bv2, rdy2} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_no_ready: bv=%b rdy=%b want 0 00", bv2, rdy2);
    end
    tick();
    brdy2 = 1'b0;
    vectors++;
    if (gnt2 !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_idle: gnt=%b want 00", gnt2);
    end
    v2 = 2'b11;
    tick();
    vectors++;
    if (gnt2 !== 2'b10) begin
      miscompares++;
      $display("FAIL abort_pointer: gnt=%b want 10", gnt2);
    end
    v2 = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req2(0, 1'b1, RGGEN_WRITE, 8'h50, 32'h3333_0000);
    brdy2 = 1'b1;
    tick();
    tick();
    brdy2 = 1'b0;
    set_req2(0, 1'b1, RGGEN_READ, 8'h50, 32'h0);
    tick();
    vectors++;
    if ({gnt2, bv2} !== 3'b01_1) begin
      miscompares++;
      $display("FAIL mid_busy: gnt=%b bv=%b want 01 1", gnt2, bv2);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bv2, gnt2, rdy2} !== 5'b0) begin
      miscompares++;
      $display("FAIL mid_async_reset: bv=%b gnt=%b rdy=%b want 0 00 00", bv2, gnt2, rdy2);
    end
    #2;
    rst_n = 1'b1;
    set_req2(1, 1'b1, RGGEN_WRITE, 8'h54, 32'h0);
    tick();
    vectors++;
    if (gnt2 !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_pointer_reset: gnt=%b want 01", gnt2);
    end
    bst2 = RGGEN_SLVERR;
    brd2 = 32'hDEADBEEF;
    brdy2 = 1'b1;
    #1;
    vectors++;
    if ({rdy2, st2, rd2, ba2} !== {2'b01, 2'b10, 32'hDEADBEEF, 2'b10}) begin
      miscompares++;
      $display("FAIL read_slverr: rdy=%b st=%b rd=%h acc=%b want 01 10 deadbeef 10", rdy2, st2, rd2, ba2);
    end
    tick();
    v2 = '0;
    brdy2 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_wrap3();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
